// File: rtl/digit_serial_adder_if.sv
// ---------------------------------------------------------------------------
// digit_serial_adder_if
//   Operand and result channels of the digit-serial adder/subtractor.
//   Both channels use valid/ready: a transfer happens on a rising clock edge
//   where valid and ready are both high. The sender holds valid and its payload
//   until that edge. The receiver may raise or lower ready independently of
//   valid.
//
//   Operand channel (producer -> adder) : in_valid, in_ready, a, b, cin, sub
//   Result channel  (adder -> consumer) : out_valid, out_ready, sum,
//                                         carry_out, overflow
//
//   master : producer/consumer side (drives operands, accepts results)
//   slave  : adder side
// ---------------------------------------------------------------------------
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/digit_serial_adder.sv
// ---------------------------------------------------------------------------
// digit_serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is added DIGIT bits
//   per clock, least significant digit first, with the carry held in a
//   register between digits. WIDTH must be an integer multiple of DIGIT.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        digit_serial_adder_if.slave (operand and result channels)
//     state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Operation
//     IDLE : in_ready high. An accepted operand pair is captured with B
//            inverted and carry preset to 1 for subtraction (a + ~b + 1).
//     RUN  : one digit per cycle; the last digit also produces carry_out and
//            overflow. out_valid rises NDIG cycles after the accepting edge.
//     DONE : out_valid high, result stable until out_ready, then IDLE.
//   Sum digits not yet reached during RUN keep the previous result.
// ---------------------------------------------------------------------------
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  digit_serial_adder_if.slave   bus,
  output logic [1:0]            state_dbg
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // already inverted for subtraction
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_full;
  logic             msb_cin;

  // Digit slice: operand digit selected by the counter, then one DIGIT-bit add.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
    dig_full = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of the digit, recovered from the sum bit.
    msb_cin  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_full[DIGIT-1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NDIG; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[i*DIGIT +: DIGIT] = dig_full[DIGIT-1:0];
          end
        end
        carry_d = dig_full[DIGIT];
        if (cnt_q == LAST) begin
          cout_d  = dig_full[DIGIT];
          ovf_d   = msb_cin ^ dig_full[DIGIT];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs decode straight from the state register, so reset
  // drives them to their idle values without waiting for a clock.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_adder
//   Three instances: WIDTH=16/DIGIT=4 (sel 0), WIDTH=4/DIGIT=1 (sel 1),
//   WIDTH=8/DIGIT=8 (sel 2). Expected results come from a reference model
//   using whole-word arithmetic and the signed-overflow sign rule.
// ---------------------------------------------------------------------------
module tb_digit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg16, dbg4, dbg8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(16)) if16 ();
  digit_serial_adder_if #(.WIDTH(4))  if4  ();
  digit_serial_adder_if #(.WIDTH(8))  if8  ();

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16), .state_dbg(dbg16));
  digit_serial_adder #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .state_dbg(dbg4));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8), .state_dbg(dbg8));

  // ---------------- driver / sampling tasks ----------------
  task automatic drive(input int w, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic sub);
    case (w)
      0: begin if16.in_valid = v; if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub; end
      1: begin if4.in_valid = v; if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = cin; if4.sub = sub; end
      default: begin if8.in_valid = v; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin; if8.sub = sub; end
    endcase
  endtask

  task automatic drive_junk(input int w);
    drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic set_ordy(input logic r);
    if16.out_ready = r;
    if4.out_ready  = r;
    if8.out_ready  = r;
  endtask

  task automatic samp(input int w, output logic ir, output logic ov,
                      output logic [15:0] s, output logic co, output logic of);
    ir = 1'b0; ov = 1'b0; s = '0; co = 1'b0; of = 1'b0;
    case (w)
      0: begin ir = if16.in_ready; ov = if16.out_valid; s = if16.sum;
               co = if16.carry_out; of = if16.overflow; end
      1: begin ir = if4.in_ready; ov = if4.out_valid; s = {12'h000, if4.sum};
               co = if4.carry_out; of = if4.overflow; end
      default: begin ir = if8.in_ready; ov = if8.out_valid; s = {8'h00, if8.sum};
               co = if8.carry_out; of = if8.overflow; end
    endcase
  endtask

  // ---------------- reference model ----------------
  // Whole-word a + b + cin, or a - b as a + ~b + 1, modulo 2^W.
  // Overflow: operands of equal sign giving a result of the other sign.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       output logic [15:0] s, output logic co, output logic of);
    int wd;
    longint unsigned m, aa, be, t, sa, sb, ss;
    wd = (w == 0) ? 16 : (w == 1) ? 4 : 8;
    m  = (64'd1 << wd) - 64'd1;
    aa = {48'd0, a} & m;
    be = sub ? (~{48'd0, b} & m) : ({48'd0, b} & m);
    t  = aa + be + (sub ? 64'd1 : {63'd0, cin});
    s  = 16'(t & m);
    co = ((t >> wd) & 64'd1) != 64'd0;
    sa = (aa >> (wd - 1)) & 64'd1;
    sb = (be >> (wd - 1)) & 64'd1;
    ss = (t  >> (wd - 1)) & 64'd1;
    of = (sa == sb) && (ss != sa);
  endtask

  function automatic int ndig_of(input int w);
    return (w == 2) ? 1 : 4;
  endfunction

  // One full operation: accept, latency, result, optional back-pressure, retire.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [15:0] es, s;
    logic eco, eof, ir, ov, co, of;
    int lat;
    bit done;
    model(w, a, b, cin, sub, es, eco, eof);
    @(negedge clk);
    samp(w, ir, ov, s, co, of);
    n_vec++;
    if (ir !== 1'b1) begin n_err++; $display("FAIL in_ready_idle w%0d: got %b want 1", w, ir); end
    drive(w, 1'b1, a, b, cin, sub);
    @(posedge clk); #1;
    drive_junk(w);
    lat = 0;
    done = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      samp(w, ir, ov, s, co, of);
      if (ov === 1'b1) done = 1;
      else if (lat == 1) begin
        n_vec++;
        if (ir !== 1'b0) begin n_err++; $display("FAIL in_ready_run w%0d: got %b want 0", w, ir); end
      end
    end
    n_vec++;
    if (!done || lat != ndig_of(w)) begin
      n_err++; $display("FAIL latency w%0d: got %0d want %0d (done=%0b)", w, lat, ndig_of(w), done);
    end
    n_vec++;
    if (s !== es) begin n_err++; $display("FAIL sum w%0d a=%h b=%h cin=%b sub=%b: got %h want %h", w, a, b, cin, sub, s, es); end
    n_vec++;
    if (co !== eco) begin n_err++; $display("FAIL carry_out w%0d a=%h b=%h sub=%b: got %b want %b", w, a, b, sub, co, eco); end
    n_vec++;
    if (of !== eof) begin n_err++; $display("FAIL overflow w%0d a=%h b=%h sub=%b: got %b want %b", w, a, b, sub, of, eof); end
    // Back-pressure: result must hold and new operands must be ignored.
    for (int h = 0; h < hold; h++) begin
      drive(w, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      @(posedge clk); #1;
      samp(w, ir, ov, s, co, of);
      n_vec++;
      if (ov !== 1'b1 || s !== es || ir !== 1'b0) begin
        n_err++; $display("FAIL hold w%0d cyc%0d: got ov=%b ir=%b sum=%h want ov=1 ir=0 sum=%h", w, h, ov, ir, s, es);
      end
    end
    drive_junk(w);
    set_ordy(1'b1);
    @(posedge clk); #1;
    samp(w, ir, ov, s, co, of);
    n_vec++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      n_err++; $display("FAIL retire w%0d: got ir=%b ov=%b want ir=1 ov=0", w, ir, ov);
    end
    set_ordy(1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic ir, ov, co, of;
    logic [15:0] s;
    set_ordy(1'b0);
    for (int w = 0; w < 3; w++) drive_junk(w);
    rst_n = 1'b0;
    #2;
    for (int w = 0; w < 3; w++) begin
      samp(w, ir, ov, s, co, of);
      n_vec++;
      if ({ir, ov, s, co, of} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL reset_state w%0d: got ir=%b ov=%b sum=%h co=%b of=%b want 1 0 0000 0 0", w, ir, ov, s, co, of);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 0);   // cin ignored when subtracting
    run_op(0, 16'h1234, 16'h1234, 1'b0, 1'b1, 0);
    run_op(0, 16'h0FFF, 16'h0000, 1'b1, 1'b0, 0);   // carry ripples through three digits
    run_op(2, 16'h0080, 16'h0080, 1'b0, 1'b0, 0);
    run_op(2, 16'h007F, 16'h00FF, 1'b0, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 3);
    run_op(1, 16'h000F, 16'h0009, 1'b1, 1'b0, 2);
  endtask

  task automatic test_reset_mid_run();
    logic ir, ov, co, of;
    logic [15:0] s;
    @(negedge clk);
    drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_junk(0);
    @(posedge clk);
    @(posedge clk); #1;       // digits 0 and 1 written, digit 2 in progress
    rst_n = 1'b0;
    #1;
    samp(0, ir, ov, s, co, of);
    n_vec++;
    if ({ir, ov, s, co, of} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_mid_run: got ir=%b ov=%b sum=%h co=%b of=%b want 1 0 0000 0 0", ir, ov, s, co, of);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      samp(0, ir, ov, s, co, of);
      n_vec++;
      if (ov !== 1'b0) begin n_err++; $display("FAIL no_result_in_reset cyc%0d: got ov=%b want 0", c, ov); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 16'h1234, 16'h0FF0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_exhaustive_4bit();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(1, 16'(a), 16'(b), 1'b0, 1'b0, 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_q[$];
    logic [17:0] e;
    logic [15:0] a, b, es, s;
    logic cin, sub, eco, eof, ir, ov, co, of;
    bit pending;
    int t, last, issued;
    set_ordy(1'b1);
    t = 0; last = -1; issued = 0;
    @(negedge clk);
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    model(0, a, b, cin, sub, es, eco, eof);
    exp_q.push_back({eco, eof, es});
    drive(0, 1'b1, a, b, cin, sub);
    pending = 1;
    for (int c = 0; c < 200 && (issued < 6 || exp_q.size() > 0); c++) begin
      samp(0, ir, ov, s, co, of);
      if (ov === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra_result: got sum=%h want no result", s);
        end else begin
          e = exp_q.pop_front();
          if ({co, of, s} !== e) begin
            n_err++; $display("FAIL b2b_result: got co=%b of=%b sum=%h want co=%b of=%b sum=%h", co, of, s, e[17], e[16], e[15:0]);
          end
        end
      end
      if (pending && ir === 1'b1) begin
        if (last >= 0) begin
          n_vec++;
          if (t - last != 6) begin n_err++; $display("FAIL b2b_interval: got %0d want 6", t - last); end
        end
        last = t;
        issued++;
        @(posedge clk); #1;
        if (issued < 6) begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
          model(0, a, b, cin, sub, es, eco, eof);
          exp_q.push_back({eco, eof, es});
          drive(0, 1'b1, a, b, cin, sub);
        end else begin
          drive_junk(0);
          pending = 0;
        end
      end
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0 || issued != 6) begin
      n_err++; $display("FAIL b2b_drain: got issued=%0d left=%0d want 6 0", issued, exp_q.size());
    end
    @(posedge clk); #1;
    set_ordy(1'b0);
  endtask

  initial begin
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_exhaustive_4bit();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
